// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: read-side master for a sync_fifo with a 1-cycle registered
// read latency. It waits until BURST_LEN words are stored (or a flush asks for
// a partial drain), then streams one burst as valid/ready beats with first/last
// markers. Read data lands in a 2-entry skid buffer, so downstream stalls never
// lose or duplicate a word.
// Optional feature macro: DRAIN_STATS_EN adds the stat_bursts and
// stat_stall_cycles counter outputs.
module fifo_burst_drain #(
  parameter int WIDTH       = 16,
  parameter int FIFO_DEPTH  = 1024,
  parameter int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1,
  parameter int BURST_LEN   = 8,
  parameter int LEN_WIDTH   = $clog2(BURST_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [COUNT_WIDTH-1:0] fifo_rd_count,
  input  logic                   flush,
  output logic                   m_valid,
  output logic [WIDTH-1:0]       m_data,
  input  logic                   m_ready,
  output logic                   m_first,
  output logic                   m_last,
  output logic                   burst_active,
  output logic [LEN_WIDTH-1:0]   burst_len
`ifdef DRAIN_STATS_EN
  ,
  output logic [15:0]            stat_bursts,
  output logic [31:0]            stat_stall_cycles
`endif
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]           state;
  logic [LEN_WIDTH-1:0] issued;
  logic [LEN_WIDTH-1:0] sent;
  logic                 pending;
  logic [1:0]           occ;
  logic [WIDTH-1:0]     skid0;
  logic [WIDTH-1:0]     skid1;
  logic                 flush_pending;

  logic                 pop;
  logic [2:0]           occ_after;
  logic                 start_thresh;
  logic                 start_flush;
  logic                 last_pop;
  logic [LEN_WIDTH-1:0] last_idx;

  // Derived control: pop, projected skid occupancy, burst start decisions, read strobe.
  always_comb begin
    pop          = m_valid && m_ready;
    occ_after    = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
    start_thresh = (state == IDLE) && (fifo_rd_count >= COUNT_WIDTH'(BURST_LEN));
    start_flush  = (state == IDLE) && !start_thresh && (flush_pending || flush) &&
                   (fifo_rd_count != {COUNT_WIDTH{1'b0}});
    last_idx     = burst_len - LEN_WIDTH'(1'b1);
    last_pop     = pop && m_last;
    // Reads are held off whenever the skid could not absorb the in-flight word.
    if ((state == STREAM) && !rst) begin
      fifo_rd_en = (issued < burst_len) && !fifo_rd_empty && (occ_after < 3'd2);
    end else begin
      fifo_rd_en = 1'b0;
    end
  end

  // Stream outputs come straight from the registered skid head and beat counter.
  always_comb begin
    m_valid      = (occ != 2'd0);
    m_data       = skid0;
    m_first      = m_valid && (sent == {LEN_WIDTH{1'b0}});
    m_last       = m_valid && (sent == last_idx);
    burst_active = (state == STREAM);
  end

  // Burst sequencing: IDLE start decision, issued/sent counters, return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_len <= {LEN_WIDTH{1'b0}};
      issued    <= {LEN_WIDTH{1'b0}};
      sent      <= {LEN_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          issued <= {LEN_WIDTH{1'b0}};
          sent   <= {LEN_WIDTH{1'b0}};
          if (start_thresh) begin
            burst_len <= LEN_WIDTH'(BURST_LEN);
            state     <= STREAM;
          end else if (start_flush) begin
            // Below threshold, so the count always fits in the length counter.
            burst_len <= LEN_WIDTH'(fifo_rd_count);
            state     <= STREAM;
          end else begin
            state <= IDLE;
          end
        end
        STREAM: begin
          if (fifo_rd_en) begin
            issued <= issued + LEN_WIDTH'(1'b1);
          end
          if (pop) begin
            sent <= sent + LEN_WIDTH'(1'b1);
          end
          if (last_pop) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Skid buffer: capture the word read last cycle, shift on pop, keep the head stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      occ     <= 2'd0;
      skid0   <= {WIDTH{1'b0}};
      skid1   <= {WIDTH{1'b0}};
    end else begin
      pending <= fifo_rd_en;
      occ     <= occ_after[1:0];
      case ({pop, pending})
        2'b01: begin
          if (occ == 2'd0) begin
            skid0 <= fifo_rd_data;
          end else begin
            skid1 <= fifo_rd_data;
          end
        end
        2'b10: begin
          skid0 <= skid1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= fifo_rd_data;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Flush request latch; a new request wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pending <= 1'b0;
    end else if (flush) begin
      flush_pending <= 1'b1;
    end else if (((state == IDLE) && (fifo_rd_count == {COUNT_WIDTH{1'b0}})) || start_flush) begin
      flush_pending <= 1'b0;
    end else begin
      flush_pending <= flush_pending;
    end
  end

`ifdef DRAIN_STATS_EN
  // Statistics: wrapping burst counter and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts       <= 16'd0;
      stat_stall_cycles <= 32'd0;
    end else begin
      if (last_pop) begin
        stat_bursts <= stat_bursts + 16'd1;
      end
      if (m_valid && !m_ready && (stat_stall_cycles != 32'hFFFF_FFFF)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Self-checking bench for fifo_burst_drain. A behavioural sync_fifo (1-cycle
// registered read) feeds the DUT; every pushed word also queues its expected
// beat (data, first, last, burst length) on a scoreboard that the negedge
// monitor pops as beats are accepted.
module tb_fifo_burst_drain;
  localparam int WIDTH       = 16;
  localparam int FIFO_DEPTH  = 1024;
  localparam int COUNT_WIDTH = 11;
  localparam int BURST_LEN   = 8;
  localparam int LEN_WIDTH   = 4;

  typedef struct {
    logic [WIDTH-1:0]     data;
    logic                 first;
    logic                 last;
    logic [LEN_WIDTH-1:0] len;
  } beat_t;

  logic                   clk;
  logic                   rst;
  logic                   fifo_rd_en;
  logic [WIDTH-1:0]       fifo_rd_data  = '0;
  logic                   fifo_rd_empty = 1'b1;
  logic [COUNT_WIDTH-1:0] fifo_rd_count = '0;
  logic                   flush;
  logic                   m_valid;
  logic [WIDTH-1:0]       m_data;
  logic                   m_ready;
  logic                   m_first;
  logic                   m_last;
  logic                   burst_active;
  logic [LEN_WIDTH-1:0]   burst_len;
`ifdef DRAIN_STATS_EN
  logic [15:0]            stat_bursts;
  logic [31:0]            stat_stall_cycles;
`endif

  logic                   push_en   = 1'b0;
  logic [WIDTH-1:0]       push_data = '0;
  logic [WIDTH-1:0]       fifo_q[$];
  beat_t                  exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int pop_count = 0;
  int valid_cycles = 0;
  int stall_total = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int ready_mode = 0;
  int ridx = 0;
  logic [3:0] ready_pat = 4'b1001;

  logic                   prev_stall = 1'b0;
  logic [WIDTH-1:0]       prev_data  = '0;
  logic                   prev_first = 1'b0;
  logic                   prev_last  = 1'b0;

  fifo_burst_drain #(
    .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .COUNT_WIDTH(COUNT_WIDTH),
    .BURST_LEN(BURST_LEN), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_count(fifo_rd_count),
    .flush(flush),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .m_first(m_first), .m_last(m_last),
    .burst_active(burst_active), .burst_len(burst_len)
`ifdef DRAIN_STATS_EN
    , .stat_bursts(stat_bursts), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural sync_fifo: registered read data, registered count/empty.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      fifo_q.delete();
      fifo_rd_data  <= '0;
      fifo_rd_count <= '0;
      fifo_rd_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && (fifo_q.size() > 0)) fifo_rd_data <= fifo_q.pop_front();
      if (push_en) fifo_q.push_back(push_data);
      fifo_rd_count <= COUNT_WIDTH'(fifo_q.size());
      fifo_rd_empty <= (fifo_q.size() == 0);
    end
  end

  // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        m_ready = 1'b1;
      end else begin
        m_ready = ready_pat[ridx % 4];
        ridx++;
      end
    end
  end

  // Monitor: scoreboard compare on accepted beats, stall stability, read-strobe legality.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en && (fifo_rd_empty || !burst_active)) viol++;
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {16'd0, m_data}, {16'd0, prev_data});
        check("stall_first", {31'd0, m_first}, {31'd0, prev_first});
        check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid) valid_cycles++;
      if (m_valid && !m_ready) stall_total++;
      if (m_valid && m_ready) begin
        pop_count++;
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", {16'd0, m_data}, {16'd0, e.data});
          check("beat_first", {31'd0, m_first}, {31'd0, e.first});
          check("beat_last", {31'd0, m_last}, {31'd0, e.last});
          check("beat_len", {28'd0, burst_len}, {28'd0, e.len});
          check("beat_active", {31'd0, burst_active}, 32'd1);
          if (e.first) first_pop_cyc = cyc;
          if (e.last) last_pop_cyc = cyc;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_first = m_first;
      prev_last  = m_last;
    end
  end

  // Push n words base+i, one per cycle, queuing expected beats grouped by grp.
  task automatic push_words(input logic [WIDTH-1:0] base, input int n, input int grp);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      push_en   = 1'b1;
      push_data = base + WIDTH'(i);
      e.data  = base + WIDTH'(i);
      e.first = ((i % grp) == 0);
      e.last  = ((i % grp) == (grp - 1));
      e.len   = LEN_WIDTH'(grp);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    push_en = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_done", {31'd0, exp_q.size() == 0}, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t_cnt;
    int t_val;
    int vc0;
    int pc0;
    int st_b0;
    rst   = 1'b1;
    flush = 1'b0;
    t_cnt = 0;
    t_val = 0;
    st_b0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_active", {31'd0, burst_active}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_len", {28'd0, burst_len}, 32'd0);
    check("rst_data", {16'd0, m_data}, 32'd0);
    check("rst_first_last", {30'd0, m_first, m_last}, 32'd0);

    // 1: full burst, latency and back-to-back beats.
    push_words(16'h1000, 8, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_count >= COUNT_WIDTH'(8)) begin t_cnt = cyc; break; end
    end
    for (int i = 0; i < 20; i++) begin
      if (m_valid) begin t_val = cyc; break; end
      @(negedge clk);
    end
    check("t1_latency", t_val - t_cnt, 32'd3);
    wait_drain(100);
    check("t1_consecutive", last_pop_cyc - first_pop_cyc, 32'd7);
    check("t1_idle_active", {31'd0, burst_active}, 32'd0);

    // 2: partial burst waits for flush.
    vc0 = valid_cycles;
    push_words(16'h00A0, 3, 3);
    repeat (50) @(posedge clk);
    check("t2_no_valid", valid_cycles - vc0, 32'd0);
    check("t2_idle", {31'd0, burst_active}, 32'd0);
    pulse_flush();
    wait_drain(100);
    vc0 = valid_cycles;
    repeat (20) @(posedge clk);
    check("t2_no_rerun", valid_cycles - vc0, 32'd0);
    check("t2_idle_after", {31'd0, burst_active}, 32'd0);

    // 3: three bursts under a 1,0,0,1 ready pattern.
`ifdef DRAIN_STATS_EN
    st_b0 = int'(stat_bursts);
`endif
    ready_mode = 1;
    push_words(16'h3000, 24, 8);
    wait_drain(400);
    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef DRAIN_STATS_EN
    check("t6_bursts", {16'd0, stat_bursts}, 32'(st_b0 + 3));
    check("t6_stalls", stat_stall_cycles, 32'(stall_total));
`endif
    check("t3_stalls_seen", {31'd0, stall_total > 0}, 32'd1);

    // 4: reset in the cycle after the 4th accepted beat.
    pc0 = pop_count;
    push_words(16'h4000, 8, 8);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (pop_count >= pc0 + 4) break;
    end
    check("t4_four_beats", pop_count - pc0, 32'd4);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_valid", {31'd0, m_valid}, 32'd0);
    check("t4_active", {31'd0, burst_active}, 32'd0);
    check("t4_rd_en", {31'd0, fifo_rd_en}, 32'd0);
`ifdef DRAIN_STATS_EN
    check("t6_rst_bursts", {16'd0, stat_bursts}, 32'd0);
    check("t6_rst_stalls", stat_stall_cycles, 32'd0);
`endif
    apply_reset();
    push_words(16'h4100, 8, 8);
    wait_drain(100);

    // 5: flush with an empty FIFO, then a small push without flush.
    vc0 = valid_cycles;
    pulse_flush();
    repeat (20) @(posedge clk);
    check("t5_no_burst", valid_cycles - vc0, 32'd0);
    check("t5_idle", {31'd0, burst_active}, 32'd0);
    push_words(16'h0500, 2, 2);
    repeat (30) @(posedge clk);
    check("t5_flush_cleared", valid_cycles - vc0, 32'd0);
    pulse_flush();
    wait_drain(100);

    check("rd_en_legal", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
Read-side master for a sync_fifo instance that feeds burst-oriented consumers such as the SDRAM write arbiter.
- Watches the FIFO fill level and starts a burst once BURST_LEN words are stored, or on a flush request.
- Drives the FIFO read port and allows for its registered 1-cycle read latency.
- Presents each burst as a valid/ready stream with first/last markers, at one beat per cycle.

Parameters:
WIDTH, 16, data word width (matches FIFO WIDTH)
FIFO_DEPTH, 1024, depth of attached FIFO
COUNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of FIFO occupancy count
BURST_LEN, 8, nominal burst length in words; must satisfy 1 <= BURST_LEN <= FIFO_DEPTH
LEN_WIDTH, $clog2(BURST_LEN+1), width of the burst length/beat counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
fifo_rd_en  output  1  FIFO read strobe
fifo_rd_data  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_empty  input  1  FIFO empty flag
fifo_rd_count  input  COUNT_WIDTH  FIFO occupancy
flush  input  1  single-cycle request to drain a partial burst
m_valid  output  1  downstream beat valid
m_data  output  WIDTH  downstream beat data
m_ready  input  1  downstream accept
m_first  output  1  first beat of burst (qualified by m_valid)
m_last  output  1  last beat of burst (qualified by m_valid)
burst_active  output  1  high while in STREAM
burst_len  output  LEN_WIDTH  length of current burst, held through STREAM

Behaviour:
- Interface is decided: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - State returns to IDLE.
  - Skid buffer is emptied; flush_pending, counters and the pending flag are cleared.
  - All outputs are 0.
  - Reset mid-burst abandons the burst. Any word already read from the FIFO is dropped. The FIFO must be reset together with this block.
- flush_pending:
  - Set by flush in any state.
  - Cleared in IDLE when fifo_rd_count == 0, or when a flush-triggered burst starts.
  - If flush arrives in the same cycle as a clear, the set wins.
- IDLE:
  - If fifo_rd_count >= BURST_LEN: burst_len <= BURST_LEN, go to STREAM.
  - Else if (flush_pending || flush) and fifo_rd_count != 0: burst_len <= fifo_rd_count, go to STREAM.
  - Else remain in IDLE.
  - The threshold test has priority over flush.
- STREAM:
  - issued counts fifo_rd_en pulses; sent counts accepted beats. Both start at 0.
  - fifo_rd_en = (issued < burst_len) && !fifo_rd_empty && (occ + pending - pop) < 2, where:
    - occ = skid occupancy (0..2);
    - pending = registered fifo_rd_en from the previous cycle;
    - pop = m_valid && m_ready.
  - When pending is 1, fifo_rd_data is written into the 2-entry skid buffer at the end of that cycle.
  - m_valid = (occ != 0); m_data = skid head.
  - m_first = (sent == 0); m_last = (sent == burst_len-1).
  - On a pop with m_last, the next state is IDLE. At least one IDLE cycle separates bursts.
- Throughput and latency:
  - One beat per cycle while m_ready is held high.
  - Count the IDLE decision cycle as cycle 0: STREAM with fifo_rd_en in cycle 1, first m_valid in cycle 3.
- m_data stability: m_data, m_first and m_last stay stable while m_valid && !m_ready.
- Deassertion of m_ready at any point must neither lose nor duplicate a word.
- fifo_rd_en is never asserted while fifo_rd_empty or outside STREAM.
- burst_active = (state == STREAM).

Optional Feature:
- Macro DRAIN_STATS_EN.
- When defined, two additional output ports:
  - stat_bursts, 16 bits: wraps; increments on every burst completion.
  - stat_stall_cycles, 32 bits: saturates at 0xFFFFFFFF; increments on every cycle with m_valid && !m_ready.
  - Both clear on rst.
- When undefined, neither port nor its logic exists.

Test Plan:
1. Push 8 words 0x1000..0x1007, m_ready=1 -> one burst with burst_len=8, beats on 8 consecutive cycles in order; m_first on 0x1000, m_last on 0x1007; first m_valid 3 cycles after count reaches 8.
2. Push 3 words 0xA0..0xA2, no flush -> no m_valid for 50 cycles. Then pulse flush -> burst_len=3, three beats, m_last on 0xA2, return to IDLE, flush_pending clear.
3. Push 24 words, m_ready toggling 1,0,0,1 pattern -> three bursts of 8, all 24 words in order with no duplicates; fifo_rd_en never seen with fifo_rd_empty=1; m_data stable during stalls.
4. Push 8 words, assert rst in the cycle after the 4th beat is accepted -> next cycle m_valid=0, burst_active=0, fifo_rd_en=0. After reset of both blocks and a push of 8 new words, a clean burst of those 8 words.
5. flush with an empty FIFO -> no burst. flush_pending stays set until the next IDLE evaluation with count==0, then clears; a later push of 2 words without flush produces no burst.
6. With DRAIN_STATS_EN: run scenario 3 -> stat_bursts=3 and stat_stall_cycles equals the bench-counted stall cycles. After rst both read 0.
